// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the memory-port arbiter: access sizes, rw
// encodings, FSM states, owners and the burst-length helper.
package mips_mem_pkg;

    localparam logic [31:0] START_ADDR = 32'h8002_0000;

    localparam logic [1:0] SIZE_1  = 2'b00;
    localparam logic [1:0] SIZE_4  = 2'b01;
    localparam logic [1:0] SIZE_8  = 2'b10;
    localparam logic [1:0] SIZE_16 = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Wide enough to hold the 16-beat maximum.
    localparam int BEAT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    typedef enum logic {
        FETCH = 1'b0,
        LS    = 1'b1
    } owner_e;

    function automatic logic [BEAT_W-1:0] burst_len(input logic [1:0] size);
        logic [BEAT_W-1:0] len;
        case (size)
            SIZE_1:  len = BEAT_W'(1);
            SIZE_4:  len = BEAT_W'(4);
            SIZE_8:  len = BEAT_W'(8);
            default: len = BEAT_W'(16);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store.
// ARB_ROUND_ROBIN_EN: alternate on ties; otherwise ls always beats fetch.
module mem_arb_pick
    import mips_mem_pkg::*;
(
    input  logic   f_req,
    input  logic   ls_req,
    input  owner_e last_owner,
    output logic   pick_valid,
    output owner_e pick_owner
);

    logic unused_last;

    always_comb begin
        pick_valid = f_req | ls_req;
        pick_owner = LS;
        if (f_req && !ls_req) begin
            pick_owner = FETCH;
        end else if (f_req && ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_owner = (last_owner == FETCH) ? LS : FETCH;
`else
            pick_owner = LS;
`endif
        end
    end

    // Only the round-robin build looks at the previous owner.
    assign unused_last = (last_owner == LS);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: grant,
// command issue, busy wait, beat collection. Optional: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_stall,
    input  logic              ls_req,
    input  logic              ls_rw,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic [1:0]        mem_access_size,
    output logic              mem_rw,
    output logic              mem_enable,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_data_out
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              rw_q, rw_d;
    logic              wr_done_q, wr_done_d;

    logic   pick_valid;
    owner_e pick_owner;
    logic   unused_addr_lsbs;

    mem_arb_pick u_pick (
        .f_req      (f_req),
        .ls_req     (ls_req),
        .last_owner (owner_q),
        .pick_valid (pick_valid),
        .pick_owner (pick_owner)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= FETCH;
            beats_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= SIZE_1;
            rw_q      <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            beats_q   <= beats_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            rw_q      <= rw_d;
            wr_done_q <= wr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beats_d    = beats_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        rw_d       = rw_q;
        wr_done_d  = 1'b0;
        f_gnt      = 1'b0;
        ls_gnt     = 1'b0;
        f_rvalid   = 1'b0;
        f_rdata    = '0;
        ls_rvalid  = 1'b0;
        ls_rdata   = '0;
        ls_done    = 1'b0;
        mem_enable = 1'b0;

        // Gating on reset_n keeps the request-driven grants quiet during reset.
        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    ls_done = wr_done_q;
                    if (pick_valid) begin
                        owner_d = pick_owner;
                        state_d = ISSUE;
                        if (pick_owner == LS) begin
                            ls_gnt  = 1'b1;
                            addr_d  = {ls_addr[ADDR_W-1:2], 2'b00};
                            rw_d    = ls_rw;
                            // Writes always move a single word.
                            size_d  = (ls_rw == RW_READ) ? ls_size : SIZE_1;
                            wdata_d = ls_wdata;
                        end else begin
                            f_gnt   = 1'b1;
                            addr_d  = {f_addr[ADDR_W-1:2], 2'b00};
                            rw_d    = RW_READ;
                            size_d  = SIZE_1;
                            wdata_d = '0;
                        end
                    end
                end
                ISSUE: begin
                    mem_enable = 1'b1;
                    if (!mem_busy) begin
                        if (rw_q == RW_READ) begin
                            state_d = DATA;
                            beats_d = burst_len(size_q);
                        end else begin
                            state_d   = IDLE;
                            wr_done_d = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (!mem_busy) begin
                        beats_d = beats_q - 1'b1;
                        if (owner_q == FETCH) begin
                            f_rvalid = 1'b1;
                            f_rdata  = mem_data_out;
                        end else begin
                            ls_rvalid = 1'b1;
                            ls_rdata  = mem_data_out;
                        end
                        if (beats_q == BEAT_W'(1)) begin
                            state_d = IDLE;
                            ls_done = (owner_q == LS);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        f_stall = reset_n & f_req & ~f_rvalid;
    end

    assign mem_address     = addr_q;
    assign mem_data_in     = wdata_q;
    assign mem_access_size = size_q;
    assign mem_rw          = mem_enable & rw_q;

    // Commands are word aligned, so requester address bits [1:0] never reach memory.
    assign unused_addr_lsbs = ^{f_addr[1:0], ls_addr[1:0]};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between the fetch stage (instruction reads) and the load/store requester (data reads/writes, program loading).
- Sequences each transaction: grant, command issue, wait on busy, beat collection, completion.
- Generates the fetch stall.
- Sits between the fetch/decode pipeline front end and the memory model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- START_ADDR, 32'h80020000, text base; used only by the bench loader

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch requests one-word read
- f_addr  in  ADDR_W  fetch PC
- f_gnt  out  1  one-cycle pulse: fetch request accepted
- f_rvalid  out  1  one-cycle pulse: f_rdata valid
- f_rdata  out  DATA_W  instruction word
- f_stall  out  1  fetch must hold PC
- ls_req  in  1  load/store request
- ls_rw  in  1  0 = write, 1 = read (memory encoding)
- ls_size  in  2  access size: 00 = 1, 01 = 4, 10 = 8, 11 = 16 words
- ls_addr  in  ADDR_W  base address
- ls_wdata  in  DATA_W  write data (single word)
- ls_gnt  out  1  one-cycle pulse: ls request accepted
- ls_rvalid  out  1  one-cycle pulse per read beat
- ls_rdata  out  DATA_W  read beat data
- ls_done  out  1  one-cycle pulse: ls transaction complete
- mem_address  out  ADDR_W  to memory address
- mem_data_in  out  DATA_W  to memory data_in
- mem_access_size  out  2  to memory access_size
- mem_rw  out  1  to memory rw
- mem_enable  out  1  to memory enable
- mem_busy  in  1  from memory busy
- mem_data_out  in  DATA_W  from memory data_out

Behaviour:
- Reset is asynchronous and active-low: `reset_n` low forces all of the following, regardless of clock:
  - state IDLE
  - all outputs 0, including `mem_rw` (it is 0 because `mem_enable` = 0 makes it inert)
  - beat counter 0
  - owner FETCH
- Reset asserted mid-transaction abandons it. No `rvalid` or `done` is issued for that transaction.
- FSM states: IDLE, ISSUE, DATA.
- IDLE:
  - Arbitration picks a winner among `f_req` and `ls_req`; default priority is ls over fetch.
  - The winner's `gnt` pulses this cycle.
  - At the edge, the arbiter registers the winner's address, rw, size and wdata.
  - The fetch winner always gets rw = 1, size 00.
  - Next state: ISSUE.
  - `mem_address[1:0]` is forced to 00.
- ISSUE:
  - `mem_enable` = 1, with the registered command driven.
  - The command is accepted at an edge where `mem_busy` = 0.
  - Write accepted: `ls_done` pulses in the following cycle, then IDLE.
  - Read accepted: go to DATA with beats = 1 / 4 / 8 / 16 per size.
  - While `mem_busy` = 1, the arbiter holds in ISSUE with the command stable.
- DATA:
  - `mem_enable` = 0.
  - Each cycle with `mem_busy` = 0 is one beat:
    - `mem_data_out` is copied combinationally to the owner's `rdata`.
    - The owner's `rvalid` pulses.
    - The beat counter decrements.
  - A cycle with `mem_busy` = 1 inserts a wait; no `rvalid` is issued.
  - On the last beat:
    - ls owner: `ls_done` pulses in the same cycle.
    - Next state: IDLE.
- Writes with `ls_size` != 00 are executed as a single word (size forced to 00).
- Timing:
  - Single-word read with no busy: req seen in cycle 0, `gnt` in cycle 0, `mem_enable` in cycle 1, `rvalid` in cycle 2.
  - Back-to-back transactions have one IDLE cycle between them.
- `f_stall` = `f_req` & ~`f_rvalid` (combinational). Fetch advances PC only in a cycle where `f_rvalid` = 1.
- A requester deasserting `req` after grant does not cancel the transaction; it completes normally.
- Both requests arriving in the same IDLE cycle: only the winner is granted; the loser stays pending, and its stall remains asserted.

Optional Feature:
- `ARB_ROUND_ROBIN_EN`.
- Defined: when both requests are present, the requester not granted last wins. The last-owner flop resets to FETCH, so ls wins the first tie. Neither requester waits more than one transaction of the other.
- Undefined: fixed priority, ls over fetch. Fetch may starve while `ls_req` is held continuously.

Decomposition:
- Package `mips_mem_pkg`:
  - access-size encodings
  - burst-length function (size -> 1/4/8/16)
  - RW_READ / RW_WRITE constants
  - FSM state enum
  - owner enum {FETCH, LS}
  - `START_ADDR`
- Sub-module `mem_arb_pick`:
  - Combinational winner selection from `f_req`, `ls_req`, last owner.
  - Contains the round-robin/priority logic, isolating the optional feature.

Test Plan:
- Reset: hold `reset_n` = 0 for 3 cycles mid-burst (ls read size 11) -> all outputs 0, state IDLE, no further `ls_rvalid`.
- Fetch single read, memory word 32'h27bdfff0 at 32'h80020000, `mem_busy` = 0 -> `f_gnt` in cycle 0, `mem_enable` in cycle 1, `f_rvalid` with 32'h27bdfff0 in cycle 2; `f_stall` = 1 in cycles 0–1, 0 in cycle 2.
- ls write: addr 32'h80020010, data 32'hdeadbeef, size 11, `mem_busy` = 1 for 2 cycles in ISSUE -> `mem_access_size` = 00, command held 3 cycles, `ls_done` one cycle after acceptance; a subsequent read returns 32'hdeadbeef.
- ls burst read size 01 with `mem_busy` = 1 on the 2nd data cycle -> exactly 4 `ls_rvalid` pulses over 5 cycles, `ls_done` on the 4th beat.
- Simultaneous `f_req` and `ls_req` held for 4 transactions:
  - Without `ARB_ROUND_ROBIN_EN`: owners LS, LS, LS, LS.
  - With `ARB_ROUND_ROBIN_EN`: owners LS, FETCH, LS, FETCH.
